trap_unit: RTL and testbench

//  Parametrised machine-mode trap unit for the veriRISCV core, at the commit stage.

---
 rtl/trap_unit.sv | 206 ++++++++++++++++++++
 tb/tb_trap_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/trap_unit.sv
// rtl/trap_unit.sv - machine-mode trap CSRs, trap arbitration and flush/redirect FSM
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   commit_*            committing instruction: valid, pc, exception vector, mret
//   fault_address/instr trap value sources for misaligned / illegal causes
//   sw/timer/ext_irq    machine interrupt levels; local_irq platform-local levels
//   csr_wr_en/addr/wdata CSR write port; csr_rdata combinational read of csr_addr
//   trap_busy           trap in progress, commit must hold
//   flush_req/flush_ack pipeline flush handshake
//   redirect_valid/pc   one-cycle PC redirect strobe and target
//   irq_pending         any enabled interrupt pending, ignoring mstatus.MIE
module trap_unit #(
    parameter int              XLEN          = 32,
    parameter int              NUM_LOCAL_IRQ = 16,
    parameter logic [XLEN-1:0] RESET_MTVEC   = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     commit_valid,
    input  logic [XLEN-1:0]          commit_pc,
    input  logic [3:0]               commit_exc,
    input  logic                     commit_mret,
    input  logic [XLEN-1:0]          fault_address,
    input  logic [XLEN-1:0]          fault_instr,
    input  logic                     sw_irq,
    input  logic                     timer_irq,
    input  logic                     ext_irq,
    input  logic [NUM_LOCAL_IRQ-1:0] local_irq,
    input  logic                     csr_wr_en,
    input  logic [11:0]              csr_addr,
    input  logic [XLEN-1:0]          csr_wdata,
    output logic [XLEN-1:0]          csr_rdata,
    output logic                     trap_busy,
    output logic                     flush_req,
    input  logic                     flush_ack,
    output logic                     redirect_valid,
    output logic [XLEN-1:0]          redirect_pc,
    output logic                     irq_pending
);

    typedef enum logic [1:0] {IDLE, DRAIN, REDIRECT} state_t;

    // Implemented interrupt bits: sw 3, timer 7, ext 11, local 16+i.
    function automatic logic [XLEN-1:0] irq_mask_f();
        logic [XLEN-1:0] m;
        m     = '0;
        m[3]  = 1'b1;
        m[7]  = 1'b1;
        m[11] = 1'b1;
        for (int i = 0; i < NUM_LOCAL_IRQ; i++) m[16+i] = 1'b1;
        return m;
    endfunction

    localparam logic [XLEN-1:0] IRQ_MASK = irq_mask_f();
    localparam logic [XLEN-1:0] LOW2     = XLEN'(3);

    state_t          state_q, state_d;
    logic            mstatus_mie_q, mstatus_mpie_q;
    logic [XLEN-1:0] mie_q, mip_q, mtvec_q, mepc_q, mcause_q, mtval_q, target_q;

    logic [XLEN-1:0] irq_vec, pend, int_code, exc_code, exc_tval, trap_cause, target_d, base;
    logic            take_exc, take_mret, take_int, capture, idle_commit;

    always_comb begin
        irq_vec                        = '0;
        irq_vec[3]                     = sw_irq;
        irq_vec[7]                     = timer_irq;
        irq_vec[11]                    = ext_irq;
        irq_vec[16 +: NUM_LOCAL_IRQ]   = local_irq;
    end

    assign pend        = mip_q & mie_q;
    assign irq_pending = |pend;

    // Interrupt cause: ext > sw > timer > lowest-numbered local line.
    always_comb begin
        int_code = '0;
        for (int i = NUM_LOCAL_IRQ - 1; i >= 0; i--) begin
            if (pend[16+i]) int_code = XLEN'(16 + i);
        end
        if (pend[7])  int_code = XLEN'(7);
        if (pend[3])  int_code = XLEN'(3);
        if (pend[11]) int_code = XLEN'(11);
    end

    // Exception cause: instr_mis > ill > load_mis > store_mis.
    always_comb begin
        exc_code = XLEN'(6);
        exc_tval = fault_address;
        if (commit_exc[2]) exc_code = XLEN'(4);
        if (commit_exc[1]) begin
            exc_code = XLEN'(2);
            exc_tval = fault_instr;
        end
        if (commit_exc[0]) begin
            exc_code = XLEN'(0);
            exc_tval = fault_address;
        end
    end

    assign idle_commit = (state_q == IDLE) && commit_valid;
    assign take_exc    = idle_commit && (|commit_exc);
    assign take_mret   = idle_commit && !(|commit_exc) && commit_mret;
    assign take_int    = idle_commit && !(|commit_exc) && !commit_mret && mstatus_mie_q && irq_pending;
    assign capture     = take_exc || take_mret || take_int;

    assign trap_cause  = take_int ? {1'b1, int_code[XLEN-2:0]} : exc_code;
    assign base        = mtvec_q & ~LOW2;

    always_comb begin
        target_d = base;
        if (take_mret)
            target_d = mepc_q;
        else if (take_int && (mtvec_q[1:0] == 2'b01))
            target_d = base + (int_code << 2);
    end

    always_comb begin
        state_d        = state_q;
        flush_req      = 1'b0;
        redirect_valid = 1'b0;
        trap_busy      = (state_q != IDLE);
        case (state_q)
            IDLE:     if (capture) state_d = DRAIN;
            DRAIN: begin
                flush_req = 1'b1;
                if (flush_ack) state_d = REDIRECT;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                state_d        = IDLE;
            end
            default:  state_d = IDLE;
        endcase
    end

    assign redirect_pc = target_q;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mip_q          <= '0;
            mtvec_q        <= RESET_MTVEC;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            target_q       <= '0;
        end else begin
            mip_q <= irq_vec & IRQ_MASK;
            if (csr_wr_en) begin
                case (csr_addr)
                    12'h300: begin
                        mstatus_mie_q  <= csr_wdata[3];
                        mstatus_mpie_q <= csr_wdata[7];
                    end
                    12'h304: mie_q    <= csr_wdata & IRQ_MASK;
                    12'h305: mtvec_q  <= csr_wdata;
                    12'h341: mepc_q   <= csr_wdata & ~LOW2;
                    12'h342: mcause_q <= csr_wdata;
                    12'h343: mtval_q  <= csr_wdata;
                    default: ;
                endcase
            end
            // Trap updates come after the CSR write so they win on a collision.
            if (take_exc || take_int) begin
                mepc_q         <= commit_pc & ~LOW2;
                mcause_q       <= trap_cause;
                mtval_q        <= take_int ? '0 : exc_tval;
                mstatus_mpie_q <= mstatus_mie_q;
                mstatus_mie_q  <= 1'b0;
            end
            if (take_mret) begin
                mstatus_mie_q  <= mstatus_mpie_q;
                mstatus_mpie_q <= 1'b1;
            end
            if (capture) target_q <= target_d;
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            12'h300: begin
                csr_rdata[3]     = mstatus_mie_q;
                csr_rdata[7]     = mstatus_mpie_q;
                csr_rdata[12:11] = 2'b11;
            end
            12'h304: csr_rdata = mie_q;
            12'h305: csr_rdata = mtvec_q;
            12'h341: csr_rdata = mepc_q;
            12'h342: csr_rdata = mcause_q;
            12'h343: csr_rdata = mtval_q;
            12'h344: csr_rdata = mip_q;
            default: csr_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_trap_unit.sv
// tb/tb_trap_unit.sv - directed self-checking bench for trap_unit
module tb_trap_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_valid, commit_mret;
    logic [31:0] commit_pc, fault_address, fault_instr, csr_wdata, csr_rdata, redirect_pc;
    logic [3:0]  commit_exc;
    logic        sw_irq, timer_irq, ext_irq;
    logic [15:0] local_irq;
    logic        csr_wr_en;
    logic [11:0] csr_addr;
    logic        trap_busy, flush_req, flush_ack, redirect_valid, irq_pending;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    trap_unit #(.XLEN(32), .NUM_LOCAL_IRQ(16), .RESET_MTVEC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_exc(commit_exc),
        .commit_mret(commit_mret), .fault_address(fault_address), .fault_instr(fault_instr),
        .sw_irq(sw_irq), .timer_irq(timer_irq), .ext_irq(ext_irq), .local_irq(local_irq),
        .csr_wr_en(csr_wr_en), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .trap_busy(trap_busy), .flush_req(flush_req), .flush_ack(flush_ack),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .irq_pending(irq_pending)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        #1;
        chk(tag, csr_rdata, exp);
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        csr_wr_en = 1'b1;
        csr_addr  = a;
        csr_wdata = d;
        step();
        csr_wr_en = 1'b0;
    endtask

    task automatic commit(input logic [31:0] pc, input logic [3:0] exc, input logic mret);
        commit_valid = 1'b1;
        commit_pc    = pc;
        commit_exc   = exc;
        commit_mret  = mret;
        step();
        commit_valid = 1'b0;
        commit_exc   = 4'b0;
        commit_mret  = 1'b0;
    endtask

    // Called in the cycle after capture: DRAIN, ack at once, one redirect strobe.
    task automatic finish_trap(input string tag, input logic [31:0] tgt);
        chk({tag, "_flush"}, flush_req, 1);
        chk({tag, "_busy"}, trap_busy, 1);
        flush_ack = 1'b1;
        step();
        flush_ack = 1'b0;
        chk({tag, "_rv"}, redirect_valid, 1);
        chk({tag, "_rpc"}, redirect_pc, tgt);
        chk({tag, "_noflush"}, flush_req, 0);
        step();
        chk({tag, "_rv_end"}, redirect_valid, 0);
        chk({tag, "_idle"}, trap_busy, 0);
    endtask

    initial begin
        rst = 1'b0; commit_valid = 0; commit_mret = 0; commit_pc = 0; commit_exc = 0;
        fault_address = 0; fault_instr = 0; sw_irq = 0; timer_irq = 0; ext_irq = 0;
        local_irq = 0; csr_wr_en = 0; csr_addr = 0; csr_wdata = 0; flush_ack = 0;
        step(); step();
        chk("rst_busy", trap_busy, 0);
        chk("rst_flush", flush_req, 0);
        chk("rst_rv", redirect_valid, 0);
        chk("rst_rpc", redirect_pc, 0);
        rd("rst_mtvec", 12'h305, 32'h0);
        rd("rst_mstatus", 12'h300, 32'h1800);
        rd("rst_mie", 12'h304, 32'h0);
        rst = 1'b1;
        step();

        // T1: illegal instruction with MIE = 0
        csr_wr(12'h305, 32'h100);
        fault_instr   = 32'hFFFF_FFFF;
        fault_address = 32'h1234;
        commit(32'h40, 4'b0010, 1'b0);
        finish_trap("t1", 32'h100);
        rd("t1_mcause", 12'h342, 32'h2);
        rd("t1_mepc", 12'h341, 32'h40);
        rd("t1_mtval", 12'h343, 32'hFFFF_FFFF);
        rd("t1_mstatus", 12'h300, 32'h1800);

        // T2: vectored, timer + ext together, ext wins
        csr_wr(12'h305, 32'h201);
        csr_wr(12'h304, 32'h880);
        csr_wr(12'h300, 32'h8);
        timer_irq = 1'b1; ext_irq = 1'b1;
        step();
        chk("t2_pending", irq_pending, 1);
        rd("t2_mip", 12'h344, 32'h880);
        commit(32'h50, 4'b0, 1'b0);
        timer_irq = 1'b0; ext_irq = 1'b0;
        finish_trap("t2", 32'h22C);
        rd("t2_mcause", 12'h342, 32'h8000_000B);
        rd("t2_mepc", 12'h341, 32'h50);
        rd("t2_mtval", 12'h343, 32'h0);
        rd("t2_mstatus", 12'h300, 32'h1880);

        // T3: mret
        csr_wr(12'h341, 32'h80);
        commit(32'h54, 4'b0, 1'b1);
        finish_trap("t3", 32'h80);
        rd("t3_mstatus", 12'h300, 32'h1888);

        // T4: delayed flush_ack, commits while busy ignored
        fault_address = 32'hDEAD_0003;
        commit_valid  = 1'b1; commit_pc = 32'h63; commit_exc = 4'b1001;
        step();
        commit_pc = 32'h999C; commit_exc = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            chk("t4_flush_held", flush_req, 1);
            chk("t4_no_rv", redirect_valid, 0);
            if (i == 4) flush_ack = 1'b1;
            step();
        end
        flush_ack = 1'b0;
        chk("t4_rv", redirect_valid, 1);
        chk("t4_rpc", redirect_pc, 32'h200);
        commit_valid = 1'b0; commit_exc = 4'b0;
        step();
        chk("t4_rv_single", redirect_valid, 0);
        chk("t4_idle", trap_busy, 0);
        rd("t4_mcause", 12'h342, 32'h0);
        rd("t4_mepc", 12'h341, 32'h60);
        rd("t4_mtval", 12'h343, 32'hDEAD_0003);
        rd("t4_mstatus", 12'h300, 32'h1880);

        // T5: exception beats pending interrupt; trap beats same-cycle mcause write
        csr_wr(12'h304, 32'h8);
        csr_wr(12'h300, 32'h8);
        sw_irq = 1'b1;
        step();
        chk("t5_pending", irq_pending, 1);
        fault_address = 32'h1235;
        csr_wr_en = 1'b1; csr_addr = 12'h342; csr_wdata = 32'h55;
        commit(32'h70, 4'b0100, 1'b0);
        csr_wr_en = 1'b0;
        finish_trap("t5e", 32'h200);
        rd("t5_mcause", 12'h342, 32'h4);
        rd("t5_mtval", 12'h343, 32'h1235);
        rd("t5_mepc", 12'h341, 32'h70);
        commit(32'h74, 4'b0, 1'b1);
        finish_trap("t5m", 32'h70);
        rd("t5_mstatus", 12'h300, 32'h1888);
        commit(32'h74, 4'b0, 1'b0);
        sw_irq = 1'b0;
        finish_trap("t5i", 32'h20C);
        rd("t5i_mcause", 12'h342, 32'h8000_0003);
        rd("t5i_mepc", 12'h341, 32'h74);

        // Local interrupt priority, mode 2 acts as direct, register masking
        csr_wr(12'h305, 32'h302);
        csr_wr(12'h304, 32'h0024_0000);
        csr_wr(12'h300, 32'h8);
        local_irq = 16'h0024;
        step();
        rd("loc_mip", 12'h344, 32'h0024_0000);
        commit(32'h80, 4'b0, 1'b0);
        local_irq = 16'h0;
        finish_trap("loc", 32'h300);
        rd("loc_mcause", 12'h342, 32'h8000_0012);
        step();
        csr_wr(12'h344, 32'hFFFF_FFFF);
        rd("mip_ro", 12'h344, 32'h0);
        csr_wr(12'h304, 32'hFFFF_FFFF);
        rd("mie_mask", 12'h304, 32'hFFFF_0888);
        rd("unmapped", 12'h123, 32'h0);

        // T6: reset during DRAIN
        commit(32'h90, 4'b0010, 1'b0);
        chk("t6_drain", flush_req, 1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("t6_flush", flush_req, 0);
        chk("t6_busy", trap_busy, 0);
        chk("t6_rv", redirect_valid, 0);
        rd("t6_mtvec", 12'h305, 32'h0);
        rd("t6_mstatus", 12'h300, 32'h1800);
        rd("t6_mepc", 12'h341, 32'h0);
        rd("t6_mie", 12'h304, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
